// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator between MIDI event decoder and oscillator bank
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2,
  parameter int STEP_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ev_valid_i,
  output logic                  ev_ready_o,
  input  logic                  ev_on_i,
  input  logic [6:0]            ev_note_i,
  input  logic [6:0]            ev_vel_i,
  input  logic [STEP_W-1:0]     ev_step_i,
  input  logic                  all_off_i,
  output logic                  voice_we_o,
  output logic [IDX_W-1:0]      voice_idx_o,
  output logic [STEP_W-1:0]     voice_step_o,
  output logic [NUM_VOICES-1:0] voice_gate_o,
  output logic                  steal_o,
  output logic                  busy_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t            state;
  logic              run_q;
  logic [IDX_W-1:0]  sc;
  logic [IDX_W-1:0]  sp;
  logic              on_q;
  logic [6:0]        note_ev;
  logic [STEP_W-1:0] step_q;
  logic              match_found;
  logic [IDX_W-1:0]  match_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [6:0]        note_q [NUM_VOICES];
  logic              set_q;
  logic              clr_q;
  logic [IDX_W-1:0]  tgt_q;

  logic              hit;
  logic              vacant;
  logic              m_found_nx;
  logic [IDX_W-1:0]  m_idx_nx;
  logic              f_found_nx;
  logic [IDX_W-1:0]  f_idx_nx;
  logic [IDX_W-1:0]  on_tgt;
  logic              steal_nx;

  // Ready is held low until the first clock after reset release and during panic
  assign ev_ready_o = run_q && (state == IDLE) && !all_off_i;
  assign busy_o     = (state != IDLE);

  // Scan results including the voice examined this cycle, and the note-on target choice
  always_comb begin
    hit        = voice_gate_o[sc] && (note_q[sc] == note_ev);
    vacant     = !voice_gate_o[sc];
    m_found_nx = match_found || hit;
    m_idx_nx   = match_found ? match_idx : sc;
    f_found_nx = free_found || vacant;
    f_idx_nx   = free_found ? free_idx : sc;
    on_tgt     = sp;
    steal_nx   = 1'b0;
    if (m_found_nx) begin
      on_tgt = m_idx_nx;
    end else if (f_found_nx) begin
      on_tgt = f_idx_nx;
    end else begin
      on_tgt   = sp;
      steal_nx = 1'b1;
    end
  end

  // Allocator FSM: IDLE -> SCAN (one voice per cycle) -> WRITE -> IDLE; gate/notes commit at end of WRITE
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      run_q        <= 1'b0;
      sc           <= '0;
      sp           <= '0;
      on_q         <= 1'b0;
      note_ev      <= '0;
      step_q       <= '0;
      match_found  <= 1'b0;
      match_idx    <= '0;
      free_found   <= 1'b0;
      free_idx     <= '0;
      set_q        <= 1'b0;
      clr_q        <= 1'b0;
      tgt_q        <= '0;
      voice_we_o   <= 1'b0;
      voice_idx_o  <= '0;
      voice_step_o <= '0;
      voice_gate_o <= '0;
      steal_o      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
      end
    end else begin
      run_q      <= 1'b1;
      voice_we_o <= 1'b0;
      steal_o    <= 1'b0;
      if (all_off_i) begin
        // Panic aborts whatever is in flight; notes and steal pointer are kept
        voice_gate_o <= '0;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid_i && ev_ready_o) begin
              // Velocity zero on a note-on is a note-off
              on_q        <= ev_on_i && (ev_vel_i != 7'd0);
              note_ev     <= ev_note_i;
              step_q      <= ev_step_i;
              sc          <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              state       <= SCAN;
            end
          end
          SCAN: begin
            match_found <= m_found_nx;
            match_idx   <= m_idx_nx;
            free_found  <= f_found_nx;
            free_idx    <= f_idx_nx;
            if (sc == LAST) begin
              state <= WRITE;
              if (on_q) begin
                voice_we_o   <= 1'b1;
                voice_idx_o  <= on_tgt;
                voice_step_o <= step_q;
                steal_o      <= steal_nx;
                tgt_q        <= on_tgt;
                set_q        <= 1'b1;
                clr_q        <= 1'b0;
              end else begin
                tgt_q <= m_idx_nx;
                set_q <= 1'b0;
                clr_q <= m_found_nx;
              end
            end else begin
              sc <= sc + 1'b1;
            end
          end
          WRITE: begin
            state <= IDLE;
            if (set_q) begin
              voice_gate_o[tgt_q] <= 1'b1;
              note_q[tgt_q]       <= note_ev;
              if (steal_o) begin
                sp <= (sp == LAST) ? '0 : sp + 1'b1;
              end
            end
            if (clr_q) begin
              voice_gate_o[tgt_q] <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard testbench for voice_allocator
module tb_voice_allocator;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [6:0]  ev_vel = '0;
  logic [31:0] ev_step = '0;
  logic        all_off = 1'b0;
  logic        voice_we;
  logic [1:0]  voice_idx;
  logic [31:0] voice_step;
  logic [3:0]  voice_gate;
  logic        steal;
  logic        busy;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] step;
    logic        stl;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  voice_allocator #(.NUM_VOICES(NV), .IDX_W(2), .STEP_W(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ev_valid_i   (ev_valid),
    .ev_ready_o   (ev_ready),
    .ev_on_i      (ev_on),
    .ev_note_i    (ev_note),
    .ev_vel_i     (ev_vel),
    .ev_step_i    (ev_step),
    .all_off_i    (all_off),
    .voice_we_o   (voice_we),
    .voice_idx_o  (voice_idx),
    .voice_step_o (voice_step),
    .voice_gate_o (voice_gate),
    .steal_o      (steal),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (steal) chk("steal_without_we", {31'd0, voice_we}, 32'd1);
    if (voice_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we_idx", {30'd0, voice_idx}, 32'hffffffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("we_idx", {30'd0, voice_idx}, {30'd0, e.idx});
        chk("we_step", voice_step, e.step);
        chk("we_steal", {31'd0, steal}, {31'd0, e.stl});
        chk("we_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel,
                      input logic [31:0] step, input logic exp_we,
                      input logic [1:0] exp_idx, input logic exp_stl);
    int n = 0;
    @(negedge clk);
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) chk("ready_timeout", 32'd0, 32'd1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_vel   = vel;
    ev_step  = step;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    if (exp_we) begin
      exp_t e;
      e.idx  = exp_idx;
      e.step = step;
      e.stl  = exp_stl;
      e.cyc  = cyc + NV;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_gate(input string name, input logic [3:0] g);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk(name, {28'd0, voice_gate}, {28'd0, g});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'd0, ev_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, ev_ready}, 32'd1);
    chk("gate_after_reset", {28'd0, voice_gate}, 32'd0);
    chk("busy_after_reset", {31'd0, busy}, 32'd0);
    chk("idx_after_reset", {30'd0, voice_idx}, 32'd0);
    chk("step_after_reset", voice_step, 32'd0);
    repeat (5) @(negedge clk);

    // Fill all voices
    send(1'b1, 7'd60, 7'd100, 32'h0100_0000, 1'b1, 2'd0, 1'b0);
    send(1'b1, 7'd62, 7'd100, 32'h0200_0000, 1'b1, 2'd1, 1'b0);
    send(1'b1, 7'd64, 7'd100, 32'h0300_0000, 1'b1, 2'd2, 1'b0);
    send(1'b1, 7'd67, 7'd100, 32'h0400_0000, 1'b1, 2'd3, 1'b0);
    idle_gate("gate_full", 4'b1111);

    // Steal voices 0 then 1
    send(1'b1, 7'd72, 7'd90, 32'h0500_0000, 1'b1, 2'd0, 1'b1);
    send(1'b1, 7'd74, 7'd90, 32'h0600_0000, 1'b1, 2'd1, 1'b1);
    idle_gate("gate_after_steal", 4'b1111);

    // Retrigger 64 on voice 2, steal pointer must stay at 2
    send(1'b1, 7'd64, 7'd80, 32'h0700_0000, 1'b1, 2'd2, 1'b0);
    idle_gate("gate_after_retrig", 4'b1111);

    // Note-offs: matched, unmatched, velocity-zero note-on
    send(1'b0, 7'd64, 7'd0, 32'h0, 1'b0, 2'd0, 1'b0);
    idle_gate("gate_off64", 4'b1011);
    send(1'b0, 7'd50, 7'd0, 32'h0, 1'b0, 2'd0, 1'b0);
    idle_gate("gate_off50", 4'b1011);
    send(1'b1, 7'd67, 7'd0, 32'h0800_0000, 1'b0, 2'd0, 1'b0);
    idle_gate("gate_vel0", 4'b0011);
    chk("idx_hold", {30'd0, voice_idx}, 32'd2);
    chk("step_hold", voice_step, 32'h0700_0000);

    // Free voices lowest-first, then steal from pointer 2
    send(1'b1, 7'd80, 7'd100, 32'h0900_0000, 1'b1, 2'd2, 1'b0);
    idle_gate("gate_free2", 4'b0111);
    send(1'b1, 7'd81, 7'd100, 32'h0a00_0000, 1'b1, 2'd3, 1'b0);
    idle_gate("gate_free3", 4'b1111);
    send(1'b1, 7'd82, 7'd100, 32'h0b00_0000, 1'b1, 2'd2, 1'b1);
    idle_gate("gate_steal_sp2", 4'b1111);

    // Panic during SCAN cycle 2
    send(1'b1, 7'd90, 7'd100, 32'h0c00_0000, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_off = 1'b1;
    #1;
    chk("ready_during_alloff", {31'd0, ev_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("gate_after_alloff", {28'd0, voice_gate}, 32'd0);
    chk("busy_after_alloff", {31'd0, busy}, 32'd0);
    @(negedge clk);
    all_off = 1'b0;
    repeat (NV + 3) @(negedge clk);

    // Event with panic held is not accepted
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    ev_note  = 7'd95;
    ev_vel   = 7'd100;
    all_off  = 1'b1;
    #1;
    chk("ready_valid_alloff", {31'd0, ev_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("busy_valid_alloff", {31'd0, busy}, 32'd0);
    ev_valid = 1'b0;
    all_off  = 1'b0;

    // After panic, gates are clear so a previously held note lands on a free voice
    send(1'b1, 7'd72, 7'd100, 32'h0d00_0000, 1'b1, 2'd0, 1'b0);
    idle_gate("gate_after_panic", 4'b0001);

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
